// File: rtl/clock_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : clock_div_ctrl
// Brief   : Run-time programmable clock divider with boundary-aligned reloads.
// Revision: 1.0 - initial release
// ============================================================================
module clock_div_ctrl #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             busy,
  output logic [CNT_W-1:0] cur_div,
  output logic             clk_out,
  output logic             tick
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_default_div = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_min_div     = CNT_W'(2);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_clk_out, w_clk_out_nxt;
  logic             r_tick, w_tick_nxt;
  logic             r_cfg_err, w_cfg_err_nxt;
  logic             r_busy, w_busy_nxt;
  logic [CNT_W-1:0] r_cur_div, w_cur_div_nxt;
  logic [CNT_W-1:0] r_pend, w_pend_nxt;

  logic [CNT_W-1:0] w_half_hi;
  logic [CNT_W-1:0] w_half_lo;
  logic             w_xfer;
  logic             w_legal;

  // Odd ratios put the extra cycle in the low phase.
  assign w_half_hi = r_cur_div >> 1;
  assign w_half_lo = r_cur_div - w_half_hi;
  assign w_xfer    = cfg_valid && !r_busy;
  assign w_legal   = (cfg_div >= c_min_div);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_clk_out_nxt = r_clk_out;
    w_tick_nxt    = 1'b0;
    w_cfg_err_nxt = w_xfer && !w_legal;
    w_busy_nxt    = r_busy;
    w_cur_div_nxt = r_cur_div;
    w_pend_nxt    = r_pend;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt     = '0;
        w_clk_out_nxt = 1'b0;
        if (w_xfer && w_legal) begin
          w_cur_div_nxt = cfg_div;
        end
        if (en) begin
          w_state_nxt   = S_HIGH;
          w_clk_out_nxt = 1'b1;
          w_tick_nxt    = 1'b1;
        end
      end

      S_HIGH: begin
        if (r_cnt == w_half_hi - c_one) begin
          w_state_nxt   = S_LOW;
          w_cnt_nxt     = '0;
          w_clk_out_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + c_one;
        end
        if (w_xfer && w_legal) begin
          w_pend_nxt = cfg_div;
          w_busy_nxt = 1'b1;
        end
      end

      S_LOW: begin
        if (r_cnt == w_half_lo - c_one) begin
          w_cnt_nxt = '0;
          if (r_busy) begin
            w_cur_div_nxt = r_pend;
            w_busy_nxt    = 1'b0;
          end
          if (en) begin
            w_state_nxt   = S_HIGH;
            w_clk_out_nxt = 1'b1;
            w_tick_nxt    = 1'b1;
          end else begin
            w_state_nxt   = S_IDLE;
            w_clk_out_nxt = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_one;
        end
        // A transfer can only occur while not busy, so it never collides with the apply above.
        if (w_xfer && w_legal) begin
          w_pend_nxt = cfg_div;
          w_busy_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt   = S_IDLE;
        w_cnt_nxt     = '0;
        w_clk_out_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_busy    <= 1'b0;
      r_cur_div <= c_default_div;
      r_pend    <= c_default_div;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_clk_out <= w_clk_out_nxt;
      r_tick    <= w_tick_nxt;
      r_cfg_err <= w_cfg_err_nxt;
      r_busy    <= w_busy_nxt;
      r_cur_div <= w_cur_div_nxt;
      r_pend    <= w_pend_nxt;
    end
  end

  assign cfg_ready = !r_busy;
  assign cfg_err   = r_cfg_err;
  assign busy      = r_busy;
  assign cur_div   = r_cur_div;
  assign clk_out   = r_clk_out;
  assign tick      = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_clock_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_clock_div_ctrl
// Brief   : Directed self-checking bench for clock_div_ctrl (scoreboard queue).
// Revision: 1.0 - initial release
// ============================================================================
module tb_clock_div_ctrl;

  logic       clk_in;
  logic       reset;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       cfg_err;
  logic       busy;
  logic [7:0] cur_div;
  logic       clk_out;
  logic       tick;

  int n_eval = 0;
  int n_fail = 0;

  typedef struct packed {
    logic       clk;
    logic       tck;
    logic       bsy;
    logic       err;
    logic [7:0] cur;
  } exp_t;

  exp_t sb[$];

  clock_div_ctrl #(
    .CNT_W       (8),
    .DEFAULT_DIV (2)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .busy      (busy),
    .cur_div   (cur_div),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clk_in cycle: drive inputs, queue the expected post-edge outputs, compare after the edge.
  task automatic step(input logic e, input logic cv, input logic [7:0] d,
                      input logic x_clk, input logic x_tick, input logic x_busy,
                      input logic x_err, input logic [7:0] x_cur);
    exp_t item;
    en        = e;
    cfg_valid = cv;
    cfg_div   = d;
    item.clk = x_clk;
    item.tck = x_tick;
    item.bsy = x_busy;
    item.err = x_err;
    item.cur = x_cur;
    sb.push_back(item);
    @(posedge clk_in);
    @(negedge clk_in);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'(1), 32'(0));
    end else begin
      item = sb.pop_front();
      chk("clk_out",   32'(clk_out),   32'(item.clk));
      chk("tick",      32'(tick),      32'(item.tck));
      chk("busy",      32'(busy),      32'(item.bsy));
      chk("cfg_ready", 32'(cfg_ready), 32'(!item.bsy));
      chk("cfg_err",   32'(cfg_err),   32'(item.err));
      chk("cur_div",   32'(cur_div),   32'(item.cur));
    end
  endtask

  // One full running period: h high cycles (tick on the first), l low cycles.
  task automatic period(input int h, input int l, input logic [7:0] cur);
    for (int i = 0; i < h; i++) step(1'b1, 1'b0, 8'd0, 1'b1, (i == 0), 1'b0, 1'b0, cur);
    for (int i = 0; i < l; i++) step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, cur);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_clk_out"},   32'(clk_out),   32'(0));
    chk({tag, "_tick"},      32'(tick),      32'(0));
    chk({tag, "_busy"},      32'(busy),      32'(0));
    chk({tag, "_cfg_ready"}, 32'(cfg_ready), 32'(1));
    chk({tag, "_cfg_err"},   32'(cfg_err),   32'(0));
    chk({tag, "_cur_div"},   32'(cur_div),   32'(2));
  endtask

  initial begin
    reset     = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = 8'd0;
    repeat (2) @(negedge clk_in);
    chk_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk_in);

    // 1: default ratio 2, toggling every cycle, then stop at the boundary
    for (int i = 0; i < 3; i++) period(1, 1, 8'd2);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);

    // 2: ratio 5 loaded in IDLE, 2 high / 3 low
    step(1'b0, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5);
    period(2, 3, 8'd5);
    period(2, 3, 8'd5);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5);

    // 3: start with ratio 4 loaded on the same edge, reload 6 mid-period
    step(1'b1, 1'b1, 8'd4, 1'b1, 1'b1, 1'b0, 1'b0, 8'd4);
    step(1'b1, 1'b1, 8'd6, 1'b1, 1'b0, 1'b1, 1'b0, 8'd4);
    step(1'b1, 1'b1, 8'd9, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4);
    step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4);
    step(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd6);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd6);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd6);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd6);

    // 4: illegal ratios rejected with an error pulse each
    step(1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd6);
    step(1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd6);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd6);

    // 5: ratio 8, en dropped in the 2nd high cycle, period completes then idles
    step(1'b0, 1'b1, 8'd8, 1'b0, 1'b0, 1'b0, 1'b0, 8'd8);
    step(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd8);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd8);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd8);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd8);

    // 6: ratio 6 running with 10 pending, asynchronous reset mid-low
    step(1'b1, 1'b1, 8'd6,  1'b1, 1'b1, 1'b0, 1'b0, 8'd6);
    step(1'b1, 1'b1, 8'd10, 1'b1, 1'b0, 1'b1, 1'b0, 8'd6);
    step(1'b1, 1'b0, 8'd0,  1'b1, 1'b0, 1'b1, 1'b0, 8'd6);
    step(1'b1, 1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b0, 8'd6);
    step(1'b1, 1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b0, 8'd6);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    @(posedge clk_in);
    @(negedge clk_in);
    chk_reset_vals("reset_held");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) period(1, 1, 8'd2);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);

    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
